dpbram_capture_writer: RTL and testbench

Trigger-qualified waveform capture controller that sits directly upstream of the single-clock dual-port block RAM and drives its write port. It writes a continuous sample stream into the RAM as a ring buffer, holds a programmable number of pre-trigger samples, fills the remaining depth with post-trigger samples, then freezes and reports the address of the oldest sample. The RAM's other port is read by the host/readout logic once the capture is done.

---
 rtl/dpbram_capture_writer_pkg.sv | 36 +++
 rtl/dpbram_capture_writer_ring_ptr.sv | 39 +++
 rtl/dpbram_capture_writer.sv | 214 +++++++++++++++++++++
 tb/tb_dpbram_capture_writer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpbram_capture_writer_pkg.sv
// ---------------------------------------------------------------------------
// dpbram_capture_writer_pkg
//
// Shared definitions for the capture writer and the readout logic that reads
// the ring buffer back out of the dual-port RAM.
//   - cap_state_t : capture controller state encoding
//   - mod_inc     : ring-buffer increment with wrap at an arbitrary depth
//   - mod_sub     : ring-buffer subtraction modulo an arbitrary depth
// The depth does not have to be a power of two, so the ring arithmetic uses
// explicit compares instead of masking.
// ---------------------------------------------------------------------------
package dpbram_capture_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT_TRIG,
      ST_POST,
      ST_DONE
   } cap_state_t;

   // Next ring position after 'value'. The last slot (depth-1) wraps to 0.
   function automatic int unsigned mod_inc(input int unsigned value,
                                           input int unsigned depth);
      return (value >= depth - 1) ? 0 : value + 1;
   endfunction

   // (a - b) mod depth, with a < depth and b < depth. When b is larger than
   // a, the difference is taken by adding one full depth first.
   function automatic int unsigned mod_sub(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned depth);
      return (a >= b) ? (a - b) : (a + depth - b);
   endfunction

endpackage

// File: rtl/dpbram_capture_writer_ring_ptr.sv
// ---------------------------------------------------------------------------
// dpbram_ring_ptr
//
// Write pointer for the capture ring buffer. Counts 0 .. RAM_DEPTH-1 and wraps
// back to 0. A load takes priority over an increment.
//
// Ports:
//   i_clk      : system clock
//   i_rst      : asynchronous active-low reset (pointer -> 0)
//   i_load     : load i_load_val into the pointer
//   i_load_val : value to load
//   i_inc      : advance the pointer by one slot, wrapping at RAM_DEPTH
//   o_ptr      : current pointer value
// ---------------------------------------------------------------------------
module dpbram_ring_ptr
   import dpbram_capture_writer_pkg::*;
#(
   parameter  int RAM_DEPTH = 1000,
   localparam int AW        = $clog2(RAM_DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic [AW-1:0] i_load_val,
   input  logic          i_inc,
   output logic [AW-1:0] o_ptr
);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_ptr <= '0;
      end else if (i_load) begin
         o_ptr <= i_load_val;
      end else if (i_inc) begin
         o_ptr <= AW'(mod_inc(32'(o_ptr), RAM_DEPTH));
      end
   end

endmodule

// File: rtl/dpbram_capture_writer.sv
// ---------------------------------------------------------------------------
// dpbram_capture_writer
//
// Trigger-qualified waveform capture controller driving the write port of a
// single-clock dual-port block RAM used as a ring buffer. After an arm it
// writes a programmable number of pre-trigger samples, keeps overwriting the
// ring while waiting for a trigger, then fills the remaining depth with
// post-trigger samples and freezes. When done it reports the trigger address
// and the address of the oldest captured sample.
//
// Configuration macro:
//   TRIG_EDGE_EN : when defined, i_trig is registered and only a 0->1
//                  transition counts as a trigger (one extra cycle of
//                  latency). When undefined, i_trig is level sensitive.
//
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-low reset
//   i_arm               : start a capture (accepted in IDLE or DONE)
//   i_abort             : return to IDLE from any state (highest priority)
//   i_pre_cnt           : pre-trigger sample count, clamped to RAM_DEPTH-1
//   i_trig              : trigger input
//   i_sample_valid/data : sample stream
//   o_bram_addr/ce/we/din : RAM write port, one cycle after sample accept
//   o_busy              : capture in progress (PRE, WAIT_TRIG, POST)
//   o_done              : capture complete, addresses valid
//   o_start_addr        : address of the oldest captured sample
//   o_trig_addr         : address of the trigger sample
// ---------------------------------------------------------------------------
module dpbram_capture_writer
   import dpbram_capture_writer_pkg::*;
#(
   parameter  int DWIDTH    = 16,
   parameter  int RAM_DEPTH = 1000,
   localparam int AW        = $clog2(RAM_DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_arm,
   input  logic              i_abort,
   input  logic [AW-1:0]     i_pre_cnt,
   input  logic              i_trig,
   input  logic              i_sample_valid,
   input  logic [DWIDTH-1:0] i_sample_data,
   output logic [AW-1:0]     o_bram_addr,
   output logic              o_bram_ce,
   output logic              o_bram_we,
   output logic [DWIDTH-1:0] o_bram_din,
   output logic              o_busy,
   output logic              o_done,
   output logic [AW-1:0]     o_start_addr,
   output logic [AW-1:0]     o_trig_addr
);

   // Sample counter must be able to hold RAM_DEPTH itself (a full post run).
   localparam int CW = $clog2(RAM_DEPTH + 1);

   cap_state_t    state;
   logic [AW-1:0] pre_target;
   logic [CW-1:0] post_target;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          pending;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] pre_clamped;
   logic [CW-1:0] post_target_next;
   logic          busy_state;
   logic          arm_ok;
   logic          wr_accept;
   logic          trig_event;
   logic          trig_take;

`ifdef TRIG_EDGE_EN
   // Edge-qualified trigger: the registered input is compared against its
   // own previous value, so a trigger held high across an arm never fires
   // until it drops and rises again.
   logic trig_q;
   logic trig_q2;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         trig_q  <= 1'b0;
         trig_q2 <= 1'b0;
      end else begin
         trig_q  <= i_trig;
         trig_q2 <= trig_q;
      end
   end

   assign trig_event = trig_q & ~trig_q2;
`else
   assign trig_event = i_trig;
`endif

   // Requests larger than the ring would leave no room for the trigger
   // sample, so they are clamped to RAM_DEPTH-1.
   assign pre_clamped      = (32'(i_pre_cnt) >= 32'(RAM_DEPTH)) ? AW'(RAM_DEPTH - 1) : i_pre_cnt;
   assign post_target_next = CW'(RAM_DEPTH) - CW'(pre_clamped);

   assign busy_state = (state == ST_PRE) || (state == ST_WAIT_TRIG) || (state == ST_POST);
   assign arm_ok     = i_arm && !i_abort && ((state == ST_IDLE) || (state == ST_DONE));
   assign wr_accept  = i_sample_valid && !i_abort && busy_state;
   assign cnt_next   = cnt + CW'(1);

   // The trigger sample is the first valid sample seen while a trigger is
   // pending or arriving in the same cycle.
   assign trig_take = (state == ST_WAIT_TRIG) && wr_accept && (pending || trig_event);

   dpbram_ring_ptr #(
      .RAM_DEPTH (RAM_DEPTH)
   ) u_ring_ptr (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (arm_ok),
      .i_load_val ('0),
      .i_inc      (wr_accept),
      .o_ptr      (wr_ptr)
   );

   // Capture FSM plus registered RAM write port. Every accepted sample is
   // presented on the write port for exactly the following cycle. o_done is
   // set one cycle after entering DONE so that it rises only after the last
   // post-trigger write has been presented.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state        <= ST_IDLE;
         pre_target   <= '0;
         post_target  <= '0;
         cnt          <= '0;
         pending      <= 1'b0;
         o_bram_addr  <= '0;
         o_bram_ce    <= 1'b0;
         o_bram_we    <= 1'b0;
         o_bram_din   <= '0;
         o_busy       <= 1'b0;
         o_done       <= 1'b0;
         o_start_addr <= '0;
         o_trig_addr  <= '0;
      end else begin
         o_bram_ce <= wr_accept;
         o_bram_we <= wr_accept;
         if (wr_accept) begin
            o_bram_addr <= wr_ptr;
            o_bram_din  <= i_sample_data;
         end

         if (i_abort) begin
            state   <= ST_IDLE;
            pending <= 1'b0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
         end else begin
            case (state)
               ST_IDLE, ST_DONE: begin
                  if (state == ST_DONE) begin
                     o_done <= 1'b1;
                  end
                  if (arm_ok) begin
                     pre_target  <= pre_clamped;
                     post_target <= post_target_next;
                     cnt         <= '0;
                     pending     <= 1'b0;
                     o_busy      <= 1'b1;
                     o_done      <= 1'b0;
                     state       <= (pre_clamped == '0) ? ST_WAIT_TRIG : ST_PRE;
                  end
               end

               ST_PRE: begin
                  if (wr_accept) begin
                     cnt <= cnt_next;
                     if (cnt_next == CW'(pre_target)) begin
                        state <= ST_WAIT_TRIG;
                     end
                  end
               end

               ST_WAIT_TRIG: begin
                  if (trig_take) begin
                     o_trig_addr  <= wr_ptr;
                     o_start_addr <= AW'(mod_sub(32'(wr_ptr), 32'(pre_target), RAM_DEPTH));
                     pending      <= 1'b0;
                     cnt          <= CW'(1);
                     if (post_target == CW'(1)) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                     end else begin
                        state <= ST_POST;
                     end
                  end else if (trig_event) begin
                     pending <= 1'b1;
                  end
               end

               ST_POST: begin
                  if (wr_accept) begin
                     cnt <= cnt_next;
                     if (cnt_next == post_target) begin
                        state  <= ST_DONE;
                        o_busy <= 1'b0;
                     end
                  end
               end

               default: begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
                  o_done <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dpbram_capture_writer.sv
// ---------------------------------------------------------------------------
// tb_dpbram_capture_writer
//
// Directed bench for dpbram_capture_writer with RAM_DEPTH = 12 (non power of
// two, AW = 4) and the default level-sensitive trigger. Inputs change 1 time
// unit after a rising edge; outputs are checked at that same point, so each
// check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_dpbram_capture_writer;

   localparam int DW    = 16;
   localparam int DEPTH = 12;
   localparam int AW    = 4;

   logic          clk;
   logic          rst_n;
   logic          arm;
   logic          abort;
   logic [AW-1:0] pre_cnt;
   logic          trig;
   logic          sample_valid;
   logic [DW-1:0] sample_data;
   logic [AW-1:0] bram_addr;
   logic          bram_ce;
   logic          bram_we;
   logic [DW-1:0] bram_din;
   logic          busy;
   logic          done;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] trig_addr;

   int checks   = 0;
   int failures = 0;
   int wr_count = 0;
   int addr_err = 0;
   int base     = 0;

   dpbram_capture_writer #(
      .DWIDTH    (DW),
      .RAM_DEPTH (DEPTH)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst_n),
      .i_arm          (arm),
      .i_abort        (abort),
      .i_pre_cnt      (pre_cnt),
      .i_trig         (trig),
      .i_sample_valid (sample_valid),
      .i_sample_data  (sample_data),
      .o_bram_addr    (bram_addr),
      .o_bram_ce      (bram_ce),
      .o_bram_we      (bram_we),
      .o_bram_din     (bram_din),
      .o_busy         (busy),
      .o_done         (done),
      .o_start_addr   (start_addr),
      .o_trig_addr    (trig_addr)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor: counts RAM writes, flags ce/we disagreeing and any
   // address beyond the last RAM slot.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bram_ce !== bram_we) addr_err++;
         if (bram_ce === 1'b1 && bram_we === 1'b1) begin
            wr_count++;
            if (bram_addr >= AW'(DEPTH)) addr_err++;
         end
      end
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [DW-1:0] data, input logic trig_in);
      sample_valid = 1'b1;
      sample_data  = data;
      trig         = trig_in;
      tick();
      sample_valid = 1'b0;
      trig         = 1'b0;
   endtask

   task automatic doArm(input logic [AW-1:0] pre);
      arm     = 1'b1;
      pre_cnt = pre;
      tick();
      arm     = 1'b0;
   endtask

   initial begin
      rst_n        = 1'b0;
      arm          = 1'b0;
      abort        = 1'b0;
      pre_cnt      = '0;
      trig         = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;

      // Reset values.
      #3;
      checkOutput("rst_ce",    32'(bram_ce),    32'd0);
      checkOutput("rst_we",    32'(bram_we),    32'd0);
      checkOutput("rst_addr",  32'(bram_addr),  32'd0);
      checkOutput("rst_din",   32'(bram_din),   32'd0);
      checkOutput("rst_busy",  32'(busy),       32'd0);
      checkOutput("rst_done",  32'(done),       32'd0);
      checkOutput("rst_start", 32'(start_addr), 32'd0);
      checkOutput("rst_trig",  32'(trig_addr),  32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Capture 1: pre=4, level trigger on 14th sample after the ring wrapped.
      // Trigger sample at (14-1) mod 12 = 1, start = (1-4) mod 12 = 9,
      // 8 post samples (14..21), 21 writes.
      base = wr_count;
      doArm(4'd4);
      checkOutput("c1_busy", 32'(busy), 32'd1);
      checkOutput("c1_done", 32'(done), 32'd0);
      applyStimulus(16'h0101, 1'b0);
      checkOutput("c1_first_ce",   32'(bram_ce),   32'd1);
      checkOutput("c1_first_we",   32'(bram_we),   32'd1);
      checkOutput("c1_first_addr", 32'(bram_addr), 32'd0);
      checkOutput("c1_first_din",  32'(bram_din),  32'h0101);
      tick();
      checkOutput("c1_idle_ce", 32'(bram_ce), 32'd0);
      for (int i = 2; i <= 13; i++) applyStimulus(16'h0100 + 16'(i), 1'b0);
      applyStimulus(16'h010E, 1'b1);
      checkOutput("c1_trig_wr_addr", 32'(bram_addr), 32'd1);
      checkOutput("c1_trig_wr_din",  32'(bram_din),  32'h010E);
      for (int i = 15; i <= 20; i++) applyStimulus(16'h0100 + 16'(i), 1'b0);
      checkOutput("c1_post_busy", 32'(busy), 32'd1);
      checkOutput("c1_post_done", 32'(done), 32'd0);
      applyStimulus(16'h0115, 1'b0);
      checkOutput("c1_last_addr", 32'(bram_addr), 32'd8);
      checkOutput("c1_last_busy", 32'(busy),      32'd0);
      checkOutput("c1_last_done", 32'(done),      32'd0);
      tick();
      checkOutput("c1_done",      32'(done),           32'd1);
      checkOutput("c1_done_ce",   32'(bram_ce),        32'd0);
      checkOutput("c1_trig_addr", 32'(trig_addr),      32'd1);
      checkOutput("c1_start",     32'(start_addr),     32'd9);
      checkOutput("c1_writes",    32'(wr_count - base), 32'd21);
      checkOutput("c1_addr_err",  32'(addr_err),       32'd0);

      // Capture 2: re-arm from DONE, pre=0, trigger on first sample.
      // Full ring of 12 writes at 0..11, trig=0, start=0.
      base = wr_count;
      doArm(4'd0);
      checkOutput("c2_busy", 32'(busy), 32'd1);
      checkOutput("c2_done", 32'(done), 32'd0);
      applyStimulus(16'h0201, 1'b1);
      checkOutput("c2_first_addr", 32'(bram_addr), 32'd0);
      for (int i = 2; i <= 11; i++) applyStimulus(16'h0200 + 16'(i), 1'b0);
      checkOutput("c2_mid_done", 32'(done), 32'd0);
      applyStimulus(16'h020C, 1'b0);
      checkOutput("c2_last_addr", 32'(bram_addr), 32'd11);
      tick();
      checkOutput("c2_done",      32'(done),            32'd1);
      checkOutput("c2_trig_addr", 32'(trig_addr),       32'd0);
      checkOutput("c2_start",     32'(start_addr),      32'd0);
      applyStimulus(16'h0299, 1'b0);
      checkOutput("c2_frozen_ce",   32'(bram_ce),         32'd0);
      checkOutput("c2_frozen_done", 32'(done),            32'd1);
      checkOutput("c2_writes",      32'(wr_count - base), 32'd12);

      // Capture 3: triggers during PRE are ignored; later a trigger pulse
      // with no valid sample, followed 5 cycles later by the trigger sample.
      // 18 samples before it, so trigger sample at 6, start = 2.
      base = wr_count;
      doArm(4'd4);
      for (int i = 1; i <= 3; i++) applyStimulus(16'h0300 + 16'(i), 1'b1);
      for (int i = 4; i <= 18; i++) applyStimulus(16'h0300 + 16'(i), 1'b0);
      tick();
      tick();
      tick();
      checkOutput("c3_wait_busy", 32'(busy), 32'd1);
      checkOutput("c3_wait_done", 32'(done), 32'd0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      tick();
      tick();
      tick();
      tick();
      checkOutput("c3_pend_ce", 32'(bram_ce), 32'd0);
      applyStimulus(16'h0319, 1'b0);
      checkOutput("c3_trig_wr_addr", 32'(bram_addr), 32'd6);
      for (int i = 20; i <= 26; i++) applyStimulus(16'h0300 + 16'(i), 1'b0);
      tick();
      checkOutput("c3_done",      32'(done),            32'd1);
      checkOutput("c3_trig_addr", 32'(trig_addr),       32'd6);
      checkOutput("c3_start",     32'(start_addr),      32'd2);
      checkOutput("c3_writes",    32'(wr_count - base), 32'd26);

      // Abort in POST together with arm, trigger and a valid sample.
      base = wr_count;
      doArm(4'd2);
      applyStimulus(16'h0401, 1'b0);
      applyStimulus(16'h0402, 1'b0);
      applyStimulus(16'h0403, 1'b1);
      abort        = 1'b1;
      arm          = 1'b1;
      trig         = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 16'h0404;
      tick();
      abort        = 1'b0;
      arm          = 1'b0;
      trig         = 1'b0;
      sample_valid = 1'b0;
      checkOutput("ab_ce",   32'(bram_ce), 32'd0);
      checkOutput("ab_busy", 32'(busy),    32'd0);
      checkOutput("ab_done", 32'(done),    32'd0);
      tick();
      checkOutput("ab_idle_busy", 32'(busy),            32'd0);
      checkOutput("ab_writes",    32'(wr_count - base), 32'd3);

      // Clamp: pre=15 becomes 11, leaving exactly one post slot.
      base = wr_count;
      doArm(4'd15);
      for (int i = 1; i <= 11; i++) applyStimulus(16'h0500 + 16'(i), 1'b0);
      applyStimulus(16'h050C, 1'b1);
      checkOutput("cl_trig_wr_addr", 32'(bram_addr), 32'd11);
      checkOutput("cl_busy",         32'(busy),      32'd0);
      tick();
      checkOutput("cl_done",      32'(done),            32'd1);
      checkOutput("cl_trig_addr", 32'(trig_addr),       32'd11);
      checkOutput("cl_start",     32'(start_addr),      32'd0);
      checkOutput("cl_writes",    32'(wr_count - base), 32'd12);

      // Reset mid-POST: everything clears immediately, without a clock edge.
      doArm(4'd1);
      applyStimulus(16'h0601, 1'b0);
      applyStimulus(16'h0602, 1'b1);
      applyStimulus(16'h0603, 1'b0);
      applyStimulus(16'h0604, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("mr_ce",    32'(bram_ce),    32'd0);
      checkOutput("mr_we",    32'(bram_we),    32'd0);
      checkOutput("mr_addr",  32'(bram_addr),  32'd0);
      checkOutput("mr_din",   32'(bram_din),   32'd0);
      checkOutput("mr_busy",  32'(busy),       32'd0);
      checkOutput("mr_done",  32'(done),       32'd0);
      checkOutput("mr_start", 32'(start_addr), 32'd0);
      checkOutput("mr_trig",  32'(trig_addr),  32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Re-arm after reset: pre=2, trigger on 3rd sample at 2, start=0,
      // 10 post samples (3..12).
      doArm(4'd2);
      applyStimulus(16'h0701, 1'b0);
      applyStimulus(16'h0702, 1'b0);
      applyStimulus(16'h0703, 1'b1);
      for (int i = 4; i <= 12; i++) applyStimulus(16'h0700 + 16'(i), 1'b0);
      tick();
      checkOutput("ra_done",      32'(done),       32'd1);
      checkOutput("ra_trig_addr", 32'(trig_addr),  32'd2);
      checkOutput("ra_start",     32'(start_addr), 32'd0);
      checkOutput("ra_addr_err",  32'(addr_err),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
